// File: rtl/ain_mac_neuron_if.sv
// ain_mac_neuron_if: stream bundle for one MAC neuron.
//   in_valid/in_ready : beat handshake carrying x, w and bias
//   x, w, bias        : signed DW-bit operands (bias used on the first beat only)
//   out_valid/out_ready : result handshake
//   out_val, out_sat  : signed OW-bit activated result and its saturation flag
// Modports: master = upstream/downstream environment, slave = the neuron.
interface ain_mac_neuron_if #(
  parameter int DW = 4,
  parameter int OW = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] w;
  logic signed [DW-1:0] bias;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_val;
  logic                 out_sat;

  modport master (
    output in_valid, x, w, bias, out_ready,
    input  in_ready, out_valid, out_val, out_sat
  );

  modport slave (
    input  in_valid, x, w, bias, out_ready,
    output in_ready, out_valid, out_val, out_sat
  );
endinterface

// File: rtl/ain_mac_neuron.sv
// ain_mac_neuron: N_IN-input neuron with a single serial multiply-accumulator.
// Beats (x, w, bias) arrive one per cycle over bus.in_*; after the N_IN-th beat
// the sum plus bias is rescaled by FRAC bits, activated, saturated to OW bits
// and held on bus.out_* until the downstream side takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset. Its deassertion is expected to be
//          synchronous to clk already.
//   bus  : ain_mac_neuron_if.slave (input beats and result handshake)
// Build option: define AIN_LEAKY_RELU_EN for a leaky activation (slope 1/8)
// with negative saturation; without it the activation is a plain ReLU.
//
// state | meaning
// IDLE  | waiting for the first beat, which also supplies the bias
// ACCUM | accumulating beats 2..N_IN
// OUT   | result valid, waiting for out_ready
module ain_mac_neuron #(
  parameter int N_IN = 4,
  parameter int DW   = 4,
  parameter int FRAC = 2,
  parameter int OW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  ain_mac_neuron_if.slave bus
);
  localparam int ACC_W = 2*DW + $clog2(N_IN) + 1;
  localparam int CNT_W = $clog2(N_IN + 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2**(OW-1)) - 1);
`ifdef AIN_LEAKY_RELU_EN
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2**(OW-1)));
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [OW-1:0]     out_val_q;
  logic                     out_sat_q;

  logic                     xfer;
  logic                     last_beat;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_al, acc_base, acc_sum, r, a;
  logic signed [OW-1:0]     val_d;
  logic                     sat_d;

  // in_ready is forced low while reset is held, even though the state is IDLE.
  assign bus.in_ready  = !rst && (state_q == IDLE || state_q == ACCUM);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_val   = out_val_q;
  assign bus.out_sat   = out_sat_q;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_beat = (state_q == ACCUM) && (cnt_q == CNT_W'(N_IN - 1));

  assign prod     = bus.x * bus.w;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  // Bias has FRAC fraction bits; products have 2*FRAC, so align it up by FRAC.
  assign bias_al  = {{(ACC_W-DW){bus.bias[DW-1]}}, bus.bias} <<< FRAC;
  assign acc_base = (state_q == IDLE) ? bias_al : acc_q;
  assign acc_sum  = acc_base + prod_ext;
  assign r        = acc_sum >>> FRAC;

  always_comb begin
    a     = '0;
    val_d = '0;
    sat_d = 1'b0;
    if (!r[ACC_W-1] && (r != '0)) begin
      a = r;
    end else begin
`ifdef AIN_LEAKY_RELU_EN
      a = r >>> 3;
`else
      a = '0;
`endif
    end
    if (a > OUT_MAX) begin
      val_d = OUT_MAX[OW-1:0];
      sat_d = 1'b1;
`ifdef AIN_LEAKY_RELU_EN
    end else if (a < OUT_MIN) begin
      val_d = OUT_MIN[OW-1:0];
      sat_d = 1'b1;
`endif
    end else begin
      val_d = a[OW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = ACCUM;
      ACCUM:   if (xfer && last_beat) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      out_val_q <= '0;
      out_sat_q <= 1'b0;
    end else if (xfer) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CNT_W'(1);
      // Result is captured on the same edge as the final beat.
      if (last_beat) begin
        out_val_q <= val_d;
        out_sat_q <= sat_d;
      end
    end else if (state_q == OUT && bus.out_ready) begin
      cnt_q <= '0;
      acc_q <= '0;
    end
  end
endmodule

// File: tb/tb_ain_mac_neuron.sv
module tb_ain_mac_neuron;
  localparam int N_IN = 4;
  localparam int DW   = 4;
  localparam int FRAC = 2;
  localparam int OW   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  ain_mac_neuron_if #(.DW(DW), .OW(OW)) bus ();

  ain_mac_neuron #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC), .OW(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int xs[N_IN];
  int ws[N_IN];
  int bias_v;
  int acc_cyc[N_IN];

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  // Reference: exact integer arithmetic on the real-valued neuron, then floor.
  function automatic void model(output int val, output bit sat);
    int acc, rr, aa, mx, mn, d;
    d   = 1 << FRAC;
    acc = bias_v * d;
    for (int k = 0; k < N_IN; k++) acc += xs[k] * ws[k];
    rr = floor_div(acc, d);
`ifdef AIN_LEAKY_RELU_EN
    aa = (rr > 0) ? rr : floor_div(rr, 8);
`else
    aa = (rr > 0) ? rr : 0;
`endif
    mx  = (1 << (OW-1)) - 1;
    mn  = -(1 << (OW-1));
    sat = 1'b0;
    val = aa;
    if (aa > mx) begin
      val = mx;
      sat = 1'b1;
    end else if (aa < mn) begin
      val = mn;
      sat = 1'b1;
    end
  endfunction

  task automatic rand_vec();
    bias_v = int'($urandom_range(0, 15)) - 8;
    for (int k = 0; k < N_IN; k++) begin
      xs[k] = int'($urandom_range(0, 15)) - 8;
      ws[k] = int'($urandom_range(0, 15)) - 8;
    end
  endtask

  task automatic send_beat(input int xv, input int wv, input int bv,
                           output bit accepted, output int at);
    logic [31:0] xt, wt, bt;
    xt = xv; wt = wv; bt = bv;
    bus.in_valid = 1'b1;
    bus.x        = xt[DW-1:0];
    bus.w        = wt[DW-1:0];
    bus.bias     = bt[DW-1:0];
    accepted = 1'b0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        at = cyc;
        accepted = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_eval(input int gap_max, input bit bias_noise, output bit ok);
    bit a;
    int g, bv;
    ok = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      g = (k == 0 || gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
      repeat (g) @(posedge clk);
      if (g > 0) #1;
      bv = (k == 0 || !bias_noise) ? bias_v : int'($urandom_range(0, 15)) - 8;
      send_beat(xs[k], ws[k], bv, a, acc_cyc[k]);
      if (!a) ok = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.w = '0; bus.bias = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_val !== '0) begin n_fail++; $display("FAIL reset_out_val got %0d want 0", $signed(bus.out_val)); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %b want 0", bus.out_sat); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_unity();
    bit ok;
    bias_v = 0;
    for (int k = 0; k < N_IN; k++) begin xs[k] = 4; ws[k] = 4; end
    drive_eval(0, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL unity_beats got timeout want accepted"); end
    n_checks++; if (acc_cyc[N_IN-1] - acc_cyc[0] !== N_IN-1) begin n_fail++; $display("FAIL unity_beat_span got %0d want %0d", acc_cyc[N_IN-1]-acc_cyc[0], N_IN-1); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL unity_latency out_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_val !== 6'sd16) begin n_fail++; $display("FAIL unity_val got %0d want 16", $signed(bus.out_val)); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL unity_sat got %b want 0", bus.out_sat); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_release out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit ok, ok2;
    bias_v = 7;
    for (int k = 0; k < N_IN; k++) begin xs[k] = -8; ws[k] = -8; end
    drive_eval(0, 1'b0, ok);
    wait_out(ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL sat_handshake got timeout want result"); end
    n_checks++; if (bus.out_val !== 6'sd31) begin n_fail++; $display("FAIL sat_val got %0d want 31", $signed(bus.out_val)); end
    n_checks++; if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", bus.out_sat); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_negative();
    bit ok, ok2;
    logic [OW-1:0] exp_v;
`ifdef AIN_LEAKY_RELU_EN
    exp_v = 6'b111110;
`else
    exp_v = 6'b000000;
`endif
    bias_v = 0;
    for (int k = 0; k < N_IN; k++) begin xs[k] = 4; ws[k] = -4; end
    drive_eval(0, 1'b0, ok);
    wait_out(ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL neg_handshake got timeout want result"); end
    n_checks++; if (bus.out_val !== exp_v) begin n_fail++; $display("FAIL neg_val got %0d want %0d", $signed(bus.out_val), $signed(exp_v)); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL neg_sat got %b want 0", bus.out_sat); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int ev, hs;
    bit es;
    logic [31:0] evt;
    rand_vec();
    drive_eval(3, 1'b1, ok);
    for (int it = 0; it < 3; it++) begin
      model(ev, es);
      evt = ev;
      wait_out(ok2);
      n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL bp_handshake it=%0d got timeout want result", it); end
      n_checks++; if (bus.out_val !== evt[OW-1:0] || bus.out_sat !== es) begin
        n_fail++; $display("FAIL bp_result it=%0d got %0d/%b want %0d/%b", it, $signed(bus.out_val), bus.out_sat, ev, es); end
      if (it < 2) rand_vec();
      bus.in_valid = 1'b1;
      bus.x = xs[0][DW-1:0]; bus.w = ws[0][DW-1:0]; bus.bias = bias_v[DW-1:0];
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_val !== evt[OW-1:0] || bus.out_sat !== es) begin
          n_fail++; $display("FAIL bp_hold it=%0d got v=%b rdy=%b val=%0d want v=1 rdy=0 val=%0d", it, bus.out_valid, bus.in_ready, $signed(bus.out_val), ev); end
      end
      if (it == 2) bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      hs = cyc;
      bus.out_ready = 1'b0;
      if (it < 2) begin
        drive_eval(3, 1'b1, ok);
        n_checks++; if (acc_cyc[0] !== hs + 1) begin n_fail++; $display("FAIL bp_first_beat it=%0d got cycle %0d want %0d", it, acc_cyc[0], hs+1); end
      end
    end
  endtask

  task automatic test_reset_midop();
    bit a, ok, ok2;
    int at;
    rand_vec();
    send_beat(xs[0], ws[0], 7, a, at);
    send_beat(xs[1], ws[1], 7, a, at);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset got v=%b rdy=%b want 0/0", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bias_v = 0;
    for (int k = 0; k < N_IN; k++) begin xs[k] = 4; ws[k] = 4; end
    drive_eval(0, 1'b0, ok);
    wait_out(ok2);
    n_checks++; if (!(ok && ok2) || bus.out_val !== 6'sd16 || bus.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL midop_fresh got %0d/%b want 16/0", $signed(bus.out_val), bus.out_sat); end
    // Reset while the result is being presented drops it at once.
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL out_reset out_valid got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ev;
    bit es;
    logic [31:0] evt;
    int firsts[3];
    bus.out_ready = 1'b1;
    for (int e = 0; e < 3; e++) begin
      rand_vec();
      model(ev, es);
      evt = ev;
      drive_eval(0, 1'b0, ok);
      firsts[e] = acc_cyc[0];
      @(negedge clk);
      n_checks++; if (!ok || bus.out_valid !== 1'b1 || bus.out_val !== evt[OW-1:0] || bus.out_sat !== es) begin
        n_fail++; $display("FAIL b2b_result e=%0d got v=%b %0d/%b want 1 %0d/%b", e, bus.out_valid, $signed(bus.out_val), bus.out_sat, ev, es); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    // Six cycles counting both first beats: N_IN beats, OUT, then the next first beat.
    for (int e = 1; e < 3; e++) begin
      n_checks++; if (firsts[e] - firsts[e-1] !== N_IN + 1) begin
        n_fail++; $display("FAIL b2b_period e=%0d got %0d want %0d", e, firsts[e]-firsts[e-1], N_IN+1); end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_negative();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
